// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the datamover write-channel arbiter.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 64;
    localparam int MEM_LEN_W  = 32;
    localparam int MEM_STS_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // Minimum width to index 'value' items, never below one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sts_id_fifo.sv
// In-order queue of requester IDs awaiting their datamover status beat.
module sts_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head_id,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin sharing of one datamover write channel; status beats are
// routed back to the issuing requester through an in-order ID queue.
module mem_write_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 512,
    parameter int STS_FIFO_DEPTH = 8,
    localparam int KEEP_W        = DATA_WIDTH / 8
) (
    input  logic                          net_clk,
    input  logic                          net_rst,

    input  logic [NUM_REQ-1:0]            s_cmd_valid,
    output logic [NUM_REQ-1:0]            s_cmd_ready,
    input  logic [NUM_REQ*MEM_ADDR_W-1:0] s_cmd_address,
    input  logic [NUM_REQ*MEM_LEN_W-1:0]  s_cmd_length,

    input  logic [NUM_REQ-1:0]            s_data_valid,
    output logic [NUM_REQ-1:0]            s_data_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data_data,
    input  logic [NUM_REQ*KEEP_W-1:0]     s_data_keep,
    input  logic [NUM_REQ-1:0]            s_data_last,

    output logic                          m_cmd_valid,
    input  logic                          m_cmd_ready,
    output logic [MEM_ADDR_W-1:0]         m_cmd_address,
    output logic [MEM_LEN_W-1:0]          m_cmd_length,

    output logic                          m_data_valid,
    input  logic                          m_data_ready,
    output logic [DATA_WIDTH-1:0]         m_data_data,
    output logic [KEEP_W-1:0]             m_data_keep,
    output logic                          m_data_last,

    input  logic                          s_sts_valid,
    output logic                          s_sts_ready,
    input  logic [MEM_STS_W-1:0]          s_sts_data,

    output logic [NUM_REQ-1:0]            m_sts_valid,
    input  logic [NUM_REQ-1:0]            m_sts_ready,
    output logic [MEM_STS_W-1:0]          m_sts_data,

    output logic                          busy,
    output logic                          sts_orphan_err
);

    localparam int ID_W  = clog2(NUM_REQ);
    localparam int CNT_W = clog2(STS_FIFO_DEPTH) + 1;

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            orphan_q, orphan_d;

    logic [ID_W-1:0]  arb_idx;
    logic             arb_hit;
    int               cand;
    logic             cmd_hs;
    logic             data_hs;
    logic             sts_pop;
    logic [ID_W-1:0]  sts_head;
    logic             sts_full;
    logic             sts_empty;
    logic [CNT_W-1:0] sts_count;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!arb_hit && s_cmd_valid[ID_W'(cand)]) begin
                arb_hit = 1'b1;
                arb_idx = ID_W'(cand);
            end
        end
    end

    assign m_cmd_address = s_cmd_address[int'(grant_q)*MEM_ADDR_W +: MEM_ADDR_W];
    assign m_cmd_length  = s_cmd_length[int'(grant_q)*MEM_LEN_W +: MEM_LEN_W];
    assign m_data_data   = s_data_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign m_data_keep   = s_data_keep[int'(grant_q)*KEEP_W +: KEEP_W];
    assign m_data_last   = s_data_last[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        m_cmd_valid  = 1'b0;
        m_data_valid = 1'b0;
        s_cmd_ready  = '0;
        s_data_ready = '0;
        cmd_hs       = 1'b0;
        data_hs      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_hit && !sts_full) begin
                    grant_d = arb_idx;
                    state_d = CMD;
                end
            end
            CMD: begin
                m_cmd_valid          = s_cmd_valid[grant_q];
                s_cmd_ready[grant_q] = m_cmd_ready;
                cmd_hs               = m_cmd_valid && m_cmd_ready;
                if (cmd_hs) begin
                    rr_ptr_d = (int'(grant_q) == NUM_REQ - 1) ? '0
                                                              : grant_q + 1'b1;
                    state_d  = DATA;
                end
            end
            DATA: begin
                m_data_valid          = s_data_valid[grant_q];
                s_data_ready[grant_q] = m_data_ready;
                data_hs               = m_data_valid && m_data_ready;
                if (data_hs && m_data_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With no owner queued, a status beat is swallowed and flagged.
    always_comb begin
        m_sts_valid = '0;
        s_sts_ready = 1'b0;
        orphan_d    = orphan_q;
        if (!sts_empty) begin
            m_sts_valid[sts_head] = s_sts_valid;
            s_sts_ready           = m_sts_ready[sts_head];
        end else begin
            s_sts_ready = s_sts_valid;
            orphan_d    = orphan_q | s_sts_valid;
        end
    end

    assign sts_pop        = s_sts_valid && s_sts_ready && !sts_empty;
    assign m_sts_data     = s_sts_data;
    assign busy           = (state_q != IDLE);
    assign sts_orphan_err = orphan_q;

    sts_id_fifo #(
        .DEPTH (STS_FIFO_DEPTH),
        .WIDTH (ID_W)
    ) u_sts_id_fifo (
        .clk     (net_clk),
        .rst     (net_rst),
        .push    (cmd_hs),
        .push_id (grant_q),
        .pop     (sts_pop),
        .head_id (sts_head),
        .full    (sts_full),
        .empty   (sts_empty),
        .count   (sts_count)
    );

    // CMD is only entered with room in the queue, so a push never overflows.
    assert property (@(posedge net_clk) disable iff (net_rst)
        !(cmd_hs && sts_full && (sts_count == CNT_W'(STS_FIFO_DEPTH))));

    always_ff @(posedge net_clk or posedge net_rst) begin
        if (net_rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            orphan_q <= orphan_d;
        end
    end

endmodule
